float_to_fixed: RTL and testbench
=================================

FLOAT_TO_FIXED -- requirements
Module: float_to_fixed

Interface
REQ-001 SHALL have parameter FRAC_BITS, default 16, meaning the number of fractional bits of the signed 32-bit fixed-point result (legal range 0..30).
REQ-002 SHALL have port clk, input, 1, the single clock; all state SHALL change on its rising edge.
REQ-003 SHALL have port reset_i, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port a_value_i, input, 32, IEEE-754 single operand (the multiplier's z_value_o), sampled only on an accepted exec_strobe_i.
REQ-005 SHALL have port exec_strobe_i, input, 1, start request, honoured only in IDLE.
REQ-006 SHALL have port z_value_o, output, 32, two's-complement fixed-point result with FRAC_BITS fraction bits.
REQ-007 SHALL have port done_strobe_o, output, 1, registered one-cycle completion pulse.

Function
REQ-008 SHALL implement FSM states IDLE, UNPACK, SPECIAL_CASES, ALIGN, ROUND, PACK, DONE.
REQ-009 SHALL, in IDLE with exec_strobe_i high, capture a_value_i and go to UNPACK; exec_strobe_i in any other state SHALL be ignored.
REQ-010 UNPACK SHALL split sign, 8-bit exponent, 23-bit fraction; unbiased exponent e = exp-127 held in a signed 10-bit register; hidden bit set when exp != 0.
REQ-011 SPECIAL_CASES SHALL resolve, then go to DONE: NaN -> 0x00000000; +inf -> 0x7FFFFFFF; -inf -> 0x80000000; zero or denormal -> 0x00000000; e+FRAC_BITS >= 32 -> saturate by sign; e+FRAC_BITS = 31 -> 0x80000000 if negative with fraction 0, otherwise saturate by sign; e+FRAC_BITS < -1 -> 0x00000000.
REQ-012 Otherwise SHALL go to ALIGN with shift count s = e+FRAC_BITS-23 (range -24..+7).
REQ-013 ALIGN SHALL shift the mantissa one bit per cycle (left if s>0, right if s<0), decrementing |s|; on right shifts the bit shifted out SHALL become guard, old guard SHALL become round, and sticky SHALL accumulate the OR of old round and sticky.
REQ-014 ALIGN SHALL exit to ROUND in the cycle |s| is zero (no shift that cycle).
REQ-015 ROUND SHALL apply round-to-nearest-even: increment magnitude when guard && (round | sticky | lsb).
REQ-016 PACK SHALL negate magnitude when sign set; positive magnitude > 0x7FFFFFFF SHALL give 0x7FFFFFFF; negative magnitude > 0x80000000 SHALL give 0x80000000.
REQ-017 done_strobe_o SHALL be high exactly in the DONE cycle, then FSM returns to IDLE; a new exec_strobe_i is accepted from the following cycle.
REQ-018 Latency: exec_strobe_i sampled in cycle 0 -> done_strobe_o high in cycle 6+|s| for ALIGN path, cycle 3 for special cases.
REQ-019 z_value_o SHALL change only in PACK or SPECIAL_CASES and SHALL hold its value until the next conversion writes it.
REQ-020 Arithmetic: magnitude register SHALL be 32 bits unsigned plus guard/round/sticky; no intermediate overflow before PACK (max left shift 7 on a 24-bit mantissa).

Reset
REQ-021 reset_i SHALL asynchronously force state IDLE, done_strobe_o 0, z_value_o 0x00000000, abandoning any conversion in progress without a done pulse.
REQ-022 After reset deassertion the block SHALL accept exec_strobe_i on the first clock edge.

Structure
REQ-023 Shared package fpu_pkg SHALL hold EXP_BIAS=127, field widths/positions, and constants FP_QNAN, FP_POS_INF, FP_NEG_INF, FIX_MAX=0x7FFFFFFF, FIX_MIN=0x80000000.
REQ-024 FSM state enum SHALL be local to the module; no sub-module is required.

Verification
REQ-025 0x3F800000 (1.0), FRAC_BITS=16 -> z=0x00010000, done in cycle 13.
REQ-026 0xC0200000 (-2.5) -> z=0xFFFD8000; 0xC7000000 (-32768.0) -> z=0x80000000 via special path, done in cycle 3.
REQ-027 0x37000000 (2^-17, exact half LSB) -> 0x00000000; 0x37400000 (1.5*2^-17) -> 0x00000001.
REQ-028 0x7F800000 -> 0x7FFFFFFF; 0xFF800000 -> 0x80000000; 0x7FC00000 -> 0x00000000; 0x47800000 (65536.0) -> 0x7FFFFFFF.
REQ-029 0x46FFFFFF (32767.998) -> 0x7FFFFF80, no saturation; exec_strobe_i pulsed mid-ALIGN -> ignored, single done pulse.
REQ-030 reset_i asserted during ALIGN -> immediate IDLE, z=0, no done pulse; next conversion of 1.0 -> 0x00010000.

Source files
------------

// File: rtl/fpu_pkg.sv
// -----------------------------------------------------------------------------
// fpu_pkg
// Shared constants for the single-precision float helpers.
//   - IEEE-754 single field widths and bit positions
//   - exponent bias
//   - special float encodings (quiet NaN, +/- infinity)
//   - signed 32-bit fixed-point saturation limits
// -----------------------------------------------------------------------------
package fpu_pkg;

    localparam int FP_W     = 32;
    localparam int EXP_W    = 8;
    localparam int FRAC_W   = 23;
    localparam int MANT_W   = FRAC_W + 1;     // fraction plus hidden bit
    localparam int SIGN_POS = 31;
    localparam int EXP_MSB  = 30;
    localparam int EXP_LSB  = 23;
    localparam int FRAC_MSB = 22;
    localparam int FRAC_LSB = 0;
    localparam int EXP_BIAS = 127;

    localparam logic [EXP_W-1:0] EXP_ALL_ONES = 8'hFF;
    localparam logic [EXP_W-1:0] EXP_ZERO     = 8'h00;

    localparam logic [FP_W-1:0] FP_QNAN    = 32'h7FC0_0000;
    localparam logic [FP_W-1:0] FP_POS_INF = 32'h7F80_0000;
    localparam logic [FP_W-1:0] FP_NEG_INF = 32'hFF80_0000;

    localparam logic [31:0] FIX_MAX  = 32'h7FFF_FFFF;
    localparam logic [31:0] FIX_MIN  = 32'h8000_0000;
    localparam logic [31:0] FIX_ZERO = 32'h0000_0000;

    // Saturated fixed-point value for a given sign.
    function automatic logic [31:0] fix_sat(input logic sign);
        return sign ? FIX_MIN : FIX_MAX;
    endfunction

endpackage

// File: rtl/float_to_fixed.sv
// -----------------------------------------------------------------------------
// float_to_fixed
// Multi-cycle converter from IEEE-754 single precision to signed 32-bit
// two's-complement fixed point with FRAC_BITS fractional bits. The mantissa is
// aligned one bit per cycle, then rounded to nearest-even and packed with
// saturation.
//
// Parameters
//   FRAC_BITS      fractional bits of the result (0..30)
// Ports
//   clk            clock, all state changes on the rising edge
//   reset_i        asynchronous active-high reset
//   a_value_i      float operand, captured on an accepted exec_strobe_i
//   exec_strobe_i  start request, only honoured in IDLE
//   z_value_o      fixed-point result, held until the next conversion writes it
//   done_strobe_o  one-cycle completion pulse (registered)
// -----------------------------------------------------------------------------
module float_to_fixed
    import fpu_pkg::*;
#(
    parameter int FRAC_BITS = 16
) (
    input  logic        clk,
    input  logic        reset_i,
    input  logic [31:0] a_value_i,
    input  logic        exec_strobe_i,
    output logic [31:0] z_value_o,
    output logic        done_strobe_o
);

    typedef enum logic [2:0] {
        IDLE,
        UNPACK,
        SPECIAL_CASES,
        ALIGN,
        ROUND,
        PACK,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic [31:0]         a_q, a_d;
    logic                sign_q, sign_d;
    logic [EXP_W-1:0]    exp_q, exp_d;
    logic [FRAC_W-1:0]   frac_q, frac_d;
    logic signed [9:0]   e_q, e_d;
    logic [31:0]         mag_q, mag_d;
    logic                guard_q, guard_d;
    logic                round_q, round_d;
    logic                sticky_q, sticky_d;
    logic [4:0]          cnt_q, cnt_d;
    logic                left_q, left_d;
    logic [31:0]         z_q, z_d;
    logic                done_q, done_d;

    // Position of the binary point relative to the mantissa MSB:
    // ef = e + FRAC_BITS is the bit index the hidden bit lands on.
    logic signed [10:0]  ef;
    logic signed [10:0]  sh;

    assign ef = {e_q[9], e_q} + 11'(FRAC_BITS);
    assign sh = ef - 11'sd23;

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            a_q      <= '0;
            sign_q   <= 1'b0;
            exp_q    <= '0;
            frac_q   <= '0;
            e_q      <= '0;
            mag_q    <= '0;
            guard_q  <= 1'b0;
            round_q  <= 1'b0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
            left_q   <= 1'b0;
            z_q      <= FIX_ZERO;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            sign_q   <= sign_d;
            exp_q    <= exp_d;
            frac_q   <= frac_d;
            e_q      <= e_d;
            mag_q    <= mag_d;
            guard_q  <= guard_d;
            round_q  <= round_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
            left_q   <= left_d;
            z_q      <= z_d;
            done_q   <= done_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and datapath logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        sign_d   = sign_q;
        exp_d    = exp_q;
        frac_d   = frac_q;
        e_d      = e_q;
        mag_d    = mag_q;
        guard_d  = guard_q;
        round_d  = round_q;
        sticky_d = sticky_q;
        cnt_d    = cnt_q;
        left_d   = left_q;
        z_d      = z_q;

        case (state_q)
            IDLE: begin
                if (exec_strobe_i) begin
                    a_d     = a_value_i;
                    state_d = UNPACK;
                end
            end

            UNPACK: begin
                sign_d   = a_q[SIGN_POS];
                exp_d    = a_q[EXP_MSB:EXP_LSB];
                frac_d   = a_q[FRAC_MSB:FRAC_LSB];
                e_d      = $signed({2'b00, a_q[EXP_MSB:EXP_LSB]}) - 10'sd127;
                mag_d    = {8'h00, (a_q[EXP_MSB:EXP_LSB] != EXP_ZERO),
                            a_q[FRAC_MSB:FRAC_LSB]};
                guard_d  = 1'b0;
                round_d  = 1'b0;
                sticky_d = 1'b0;
                state_d  = SPECIAL_CASES;
            end

            SPECIAL_CASES: begin
                state_d = DONE;
                if (exp_q == EXP_ALL_ONES) begin
                    // NaN converts to zero, infinities saturate
                    z_d = (frac_q != '0) ? FIX_ZERO : fix_sat(sign_q);
                end else if (exp_q == EXP_ZERO) begin
                    z_d = FIX_ZERO;
                end else if (ef >= 11'sd32) begin
                    z_d = fix_sat(sign_q);
                end else if (ef == 11'sd31) begin
                    // Only -2^31 exactly is representable at this magnitude.
                    z_d = fix_sat(sign_q);
                end else if (ef < -11'sd1) begin
                    // Below half an LSB: rounds to zero.
                    z_d = FIX_ZERO;
                end else begin
                    left_d  = !sh[10];
                    cnt_d   = 5'(sh[10] ? -sh : sh);
                    state_d = ALIGN;
                end
            end

            ALIGN: begin
                if (cnt_q == 5'd0) begin
                    state_d = ROUND;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                    if (left_q) begin
                        mag_d = mag_q << 1;
                    end else begin
                        mag_d    = mag_q >> 1;
                        guard_d  = mag_q[0];
                        round_d  = guard_q;
                        sticky_d = sticky_q | round_q;
                    end
                end
            end

            ROUND: begin
                if (guard_q && (round_q || sticky_q || mag_q[0])) begin
                    mag_d = mag_q + 32'd1;
                end
                state_d = PACK;
            end

            PACK: begin
                if (sign_q) begin
                    z_d = (mag_q > FIX_MIN) ? FIX_MIN : (~mag_q + 32'd1);
                end else begin
                    z_d = (mag_q > FIX_MAX) ? FIX_MAX : mag_q;
                end
                state_d = DONE;
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Registered pulse: high for exactly the cycle spent in DONE.
        done_d = (state_d == DONE);
    end

    assign z_value_o     = z_q;
    assign done_strobe_o = done_q;

endmodule

// File: tb/tb_float_to_fixed.sv
// -----------------------------------------------------------------------------
// tb_float_to_fixed
// Directed vectors with hand-computed results for FRAC_BITS = 16, including
// latency, single done pulse, result hold, strobe-while-busy and reset abort.
// -----------------------------------------------------------------------------
module tb_float_to_fixed;

    logic        clk = 1'b0;
    logic        reset_i;
    logic [31:0] a_value_i;
    logic        exec_strobe_i;
    logic [31:0] z_value_o;
    logic        done_strobe_o;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    float_to_fixed #(.FRAC_BITS(16)) dut (
        .clk          (clk),
        .reset_i      (reset_i),
        .a_value_i    (a_value_i),
        .exec_strobe_i(exec_strobe_i),
        .z_value_o    (z_value_o),
        .done_strobe_o(done_strobe_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
        end
    endtask

    // Called at a falling edge. Launches one conversion and checks latency
    // (cycle index of done_strobe_o, cycle 0 = strobe sampled), result,
    // absence of a second done pulse, and that the result is held.
    // strobe_at > 0 pulses exec_strobe_i again in that cycle (must be ignored).
    task automatic convert(input string tag, input logic [31:0] a,
                           input logic [31:0] want_z, input int want_cyc,
                           input int strobe_at);
        int cyc;
        int extra;
        a_value_i     = a;
        exec_strobe_i = 1'b1;
        cyc = 0;
        for (int i = 1; i <= 64; i++) begin
            @(negedge clk);
            if (i == 1) begin
                exec_strobe_i = 1'b0;
                a_value_i     = 32'hDEAD_BEEF;
            end
            if (strobe_at > 0 && i == strobe_at) begin
                exec_strobe_i = 1'b1;
                a_value_i     = 32'h4000_0000;
            end
            if (strobe_at > 0 && i == strobe_at + 1) begin
                exec_strobe_i = 1'b0;
            end
            if (done_strobe_o) begin
                cyc = i;
                break;
            end
        end
        exec_strobe_i = 1'b0;
        check({tag, "/latency"}, 32'(cyc), 32'(want_cyc));
        check({tag, "/z"}, z_value_o, want_z);
        extra = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done_strobe_o) extra++;
        end
        check({tag, "/single_done"}, 32'(extra), 32'd0);
        check({tag, "/z_hold"}, z_value_o, want_z);
        $display("conv %-12s a=0x%08h z=0x%08h done@%0d (want 0x%08h @%0d)",
                 tag, a, z_value_o, cyc, want_z, want_cyc);
    endtask

    initial begin
        reset_i       = 1'b1;
        a_value_i     = 32'h0;
        exec_strobe_i = 1'b0;
        repeat (2) @(negedge clk);
        check("reset/z", z_value_o, 32'h0000_0000);
        check("reset/done", {31'd0, done_strobe_o}, 32'd0);
        $display("reset  z=0x%08h done=%0b", z_value_o, done_strobe_o);

        // Strobe applied in the same cycle reset is released.
        reset_i = 1'b0;
        convert("one",      32'h3F80_0000, 32'h0001_0000, 13, 0);
        convert("neg_one",  32'hBF80_0000, 32'hFFFF_0000, 13, 0);
        convert("m2p5",     32'hC020_0000, 32'hFFFD_8000, 12, 0);
        convert("m32768",   32'hC700_0000, 32'h8000_0000,  3, 0);
        convert("p32768",   32'h4700_0000, 32'h7FFF_FFFF,  3, 0);
        convert("m32768p",  32'hC700_0001, 32'h8000_0000,  3, 0);
        convert("half_lsb", 32'h3700_0000, 32'h0000_0000, 30, 0);
        convert("1p5_lsb",  32'h3740_0000, 32'h0000_0001, 30, 0);
        convert("tie_up",   32'h37C0_0000, 32'h0000_0002, 29, 0);
        convert("tie_down", 32'h3820_0000, 32'h0000_0002, 28, 0);
        convert("tiny",     32'h3680_0000, 32'h0000_0000,  3, 0);
        convert("pinf",     32'h7F80_0000, 32'h7FFF_FFFF,  3, 0);
        convert("ninf",     32'hFF80_0000, 32'h8000_0000,  3, 0);
        convert("nan",      32'h7FC0_0000, 32'h0000_0000,  3, 0);
        convert("zero",     32'h0000_0000, 32'h0000_0000,  3, 0);
        convert("denorm",   32'h8000_0001, 32'h0000_0000,  3, 0);
        convert("p65536",   32'h4780_0000, 32'h7FFF_FFFF,  3, 0);
        convert("max_left", 32'h46FF_FFFF, 32'h7FFF_FF80, 13, 5);

        // Abort a conversion of 1.0 while it is aligning.
        a_value_i     = 32'h3F80_0000;
        exec_strobe_i = 1'b1;
        @(negedge clk);
        exec_strobe_i = 1'b0;
        repeat (3) @(negedge clk);
        reset_i = 1'b1;
        #1;
        check("abort/z", z_value_o, 32'h0000_0000);
        check("abort/done", {31'd0, done_strobe_o}, 32'd0);
        @(negedge clk);
        check("abort/done_held", {31'd0, done_strobe_o}, 32'd0);
        $display("abort  z=0x%08h done=%0b", z_value_o, done_strobe_o);
        reset_i = 1'b0;
        convert("after_rst", 32'h3F80_0000, 32'h0001_0000, 13, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
